// File: rtl/processing_cell_fifo.sv
// processing_cell_fifo: CGRA processing cell. Two operands are picked from
// neighbour ports or a constant and queued in per-operand FIFOs. An ALU
// (optionally accumulating) produces one token per fire, and an eager fork
// delivers it to every destination in fork_mask.

module processing_cell_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int SEL_W      = $clog2(NUM_PORTS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]            din_v,
  output logic [NUM_PORTS-1:0]            din_r,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic [NUM_PORTS-1:0]            dout_v,
  input  logic [NUM_PORTS-1:0]            dout_r,
  input  logic [SEL_W-1:0]                sel_1,
  input  logic [SEL_W-1:0]                sel_2,
  input  logic [2:0]                      op,
  input  logic                            acc_mode,
  input  logic [15:0]                     iterations,
  input  logic [DATA_WIDTH-1:0]           const_val,
  input  logic [NUM_PORTS-1:0]            fork_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [SEL_W-1:0] SEL_CONST = SEL_W'(NUM_PORTS);

  // operand FIFO state
  logic [DATA_WIDTH-1:0] mem1_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem1_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem2_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem2_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr1_q, wptr1_d, rptr1_q, rptr1_d;
  logic [PTR_W-1:0]      wptr2_q, wptr2_d, rptr2_q, rptr2_d;
  logic [CNT_W-1:0]      cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  // output register / fork state
  logic                  ofull_q, ofull_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NUM_PORTS-1:0]  sent_q, sent_d;
  logic [NUM_PORTS-1:0]  dout_v_q, dout_v_d;
  logic [NUM_PORTS-1:0]  din_r_q, din_r_d;

  // accumulator state
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]           acc_cnt_q, acc_cnt_d;

  // combinational helpers
  logic [NUM_PORTS-1:0]  sel1_hit_s, sel2_hit_s, din_r_rst_s;
  logic                  sel1_const_s, sel2_const_s;
  logic                  src1_v_s, src2_v_s;
  logic [DATA_WIDTH-1:0] src1_data_s, src2_data_s;
  logic                  full1_s, full2_s, empty1_s, empty2_s;
  logic                  full1_n_s, full2_n_s;
  logic                  push1_s, push2_s, pop1_s, pop2_s;
  logic [NUM_PORTS-1:0]  accepted_s;
  logic                  retire_s, fire_s;
  logic [DATA_WIDTH-1:0] a_s, b_s, res_s;
  logic [15:0]           acc_cnt_inc_s;

  // Decode operand selects; operand 2 is unused in accumulate mode.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel1_hit_s[i] = (sel_1 == SEL_W'(i));
      sel2_hit_s[i] = (sel_2 == SEL_W'(i)) & ~acc_mode;
    end
    sel1_const_s = (sel_1 == SEL_CONST);
    sel2_const_s = (sel_2 == SEL_CONST) & ~acc_mode;
    din_r_rst_s  = sel1_hit_s | sel2_hit_s;
  end

  // Operand source mux (one-hot AND-OR); a port beat counts only when the port is ready.
  always_comb begin
    src1_data_s = const_val & {DATA_WIDTH{sel1_const_s}};
    src2_data_s = const_val & {DATA_WIDTH{sel2_const_s}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      src1_data_s = src1_data_s | (din[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel1_hit_s[i]}});
      src2_data_s = src2_data_s | (din[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel2_hit_s[i]}});
    end
    src1_v_s = (|(sel1_hit_s & din_v & din_r_q)) | sel1_const_s;
    src2_v_s = (|(sel2_hit_s & din_v & din_r_q)) | sel2_const_s;
  end

  // FIFO status and handshake / fire decision.
  always_comb begin
    full1_s    = (cnt1_q == DEPTH_C);
    full2_s    = (cnt2_q == DEPTH_C);
    empty1_s   = (cnt1_q == {CNT_W{1'b0}});
    empty2_s   = (cnt2_q == {CNT_W{1'b0}});
    push1_s    = src1_v_s & ~full1_s;
    push2_s    = src2_v_s & ~full2_s & ~acc_mode;
    accepted_s = dout_v_q & dout_r;
    retire_s   = ofull_q & (((sent_q | accepted_s) & fork_mask) == fork_mask);
    fire_s     = ~empty1_s & (acc_mode | ~empty2_s) & (~ofull_q | retire_s);
    pop1_s     = fire_s;
    pop2_s     = fire_s & ~acc_mode;
  end

  // ALU on the FIFO heads; operand B is the accumulator in accumulate mode.
  always_comb begin
    a_s = mem1_q[rptr1_q];
    b_s = acc_mode ? acc_q : mem2_q[rptr2_q];
    case (op)
      3'd0:    res_s = a_s + b_s;
      3'd1:    res_s = a_s - b_s;
      3'd2:    res_s = a_s * b_s;
      3'd3:    res_s = a_s & b_s;
      3'd4:    res_s = a_s | b_s;
      3'd5:    res_s = a_s ^ b_s;
      3'd6:    res_s = a_s << b_s[SH_W-1:0];
      3'd7:    res_s = $unsigned($signed(a_s) >>> b_s[SH_W-1:0]);
      default: res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // FIFO next state; full ignores a same-cycle pop.
  always_comb begin
    mem1_d = mem1_q;
    mem2_d = mem2_q;
    if (push1_s) begin
      mem1_d[wptr1_q] = src1_data_s;
    end else begin
      mem1_d[wptr1_q] = mem1_q[wptr1_q];
    end
    if (push2_s) begin
      mem2_d[wptr2_q] = src2_data_s;
    end else begin
      mem2_d[wptr2_q] = mem2_q[wptr2_q];
    end
    wptr1_d = wptr1_q + PTR_W'(push1_s);
    rptr1_d = rptr1_q + PTR_W'(pop1_s);
    cnt1_d  = cnt1_q + CNT_W'(push1_s) - CNT_W'(pop1_s);
    wptr2_d = wptr2_q + PTR_W'(push2_s);
    rptr2_d = rptr2_q + PTR_W'(pop2_s);
    cnt2_d  = cnt2_q + CNT_W'(push2_s) - CNT_W'(pop2_s);
  end

  // Next-cycle input ready: a port is ready when every FIFO it feeds has room.
  always_comb begin
    full1_n_s = (cnt1_d == DEPTH_C);
    full2_n_s = (cnt2_d == DEPTH_C);
    for (int i = 0; i < NUM_PORTS; i++) begin
      din_r_d[i] = (sel1_hit_s[i] | sel2_hit_s[i])
                 & ~(sel1_hit_s[i] & full1_n_s)
                 & ~(sel2_hit_s[i] & full2_n_s);
    end
  end

  // Accumulator: take the result each accumulate fire, reload every `iterations` fires.
  always_comb begin
    acc_cnt_inc_s = acc_cnt_q + 16'd1;
    if (fire_s & acc_mode) begin
      if ((iterations != 16'd0) && (acc_cnt_inc_s == iterations)) begin
        acc_d     = const_val;
        acc_cnt_d = 16'd0;
      end else begin
        acc_d     = res_s;
        acc_cnt_d = acc_cnt_inc_s;
      end
    end else begin
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
    end
  end

  // Eager fork: load on fire, track per-destination delivery, retire when all masked sent.
  always_comb begin
    if (fire_s & (|fork_mask)) begin
      ofull_d = 1'b1;
      dout_d  = res_s;
      sent_d  = {NUM_PORTS{1'b0}};
    end else if (retire_s) begin
      ofull_d = 1'b0;
      dout_d  = dout_q;
      sent_d  = {NUM_PORTS{1'b0}};
    end else begin
      ofull_d = ofull_q;
      dout_d  = dout_q;
      sent_d  = sent_q | accepted_s;
    end
    dout_v_d = {NUM_PORTS{ofull_d}} & fork_mask & ~sent_d;
  end

  // Control state registers with synchronous reset / flush.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr1_q   <= {PTR_W{1'b0}};
      rptr1_q   <= {PTR_W{1'b0}};
      cnt1_q    <= {CNT_W{1'b0}};
      wptr2_q   <= {PTR_W{1'b0}};
      rptr2_q   <= {PTR_W{1'b0}};
      cnt2_q    <= {CNT_W{1'b0}};
      ofull_q   <= 1'b0;
      dout_q    <= {DATA_WIDTH{1'b0}};
      sent_q    <= {NUM_PORTS{1'b0}};
      dout_v_q  <= {NUM_PORTS{1'b0}};
      din_r_q   <= din_r_rst_s;
      acc_q     <= const_val;
      acc_cnt_q <= 16'd0;
    end else begin
      wptr1_q   <= wptr1_d;
      rptr1_q   <= rptr1_d;
      cnt1_q    <= cnt1_d;
      wptr2_q   <= wptr2_d;
      rptr2_q   <= rptr2_d;
      cnt2_q    <= cnt2_d;
      ofull_q   <= ofull_d;
      dout_q    <= dout_d;
      sent_q    <= sent_d;
      dout_v_q  <= dout_v_d;
      din_r_q   <= din_r_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge clk) begin
    mem1_q <= mem1_d;
    mem2_q <= mem2_d;
  end

  assign din_r  = din_r_q;
  assign dout   = dout_q;
  assign dout_v = dout_v_q;

endmodule

// File: tb/tb_processing_cell_fifo.sv
// Bench for processing_cell_fifo: queue-based reference model compared every
// cycle, plus literal expectations for each directed scenario.

module tb_processing_cell_fifo;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int FD = 2;
  localparam int SW = $clog2(NP + 1);
  localparam int SH = $clog2(DW);

  logic            clk = 1'b0;
  logic            rst, clr;
  logic [NP*DW-1:0] din;
  logic [NP-1:0]   din_v, din_r, dout_v, dout_r, fork_mask;
  logic [DW-1:0]   dout, const_val;
  logic [SW-1:0]   sel_1, sel_2;
  logic [2:0]      op;
  logic            acc_mode;
  logic [15:0]     iterations;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // reference model state
  logic [DW-1:0] m_q1[$], m_q2[$];
  bit            m_tok;
  logic [NP-1:0] m_sent;
  logic [DW-1:0] m_acc, m_dout;
  int            m_cnt;

  // observed / expected transfer logs
  logic [DW-1:0] got_dut[$], got_mdl[$], exp_q[$];
  int            dlv_dut[NP];
  logic [DW-1:0] alu_lit[8];

  processing_cell_fifo #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .din(din), .din_v(din_v), .din_r(din_r),
    .dout(dout), .dout_v(dout_v), .dout_r(dout_r),
    .sel_1(sel_1), .sel_2(sel_2), .op(op), .acc_mode(acc_mode),
    .iterations(iterations), .const_val(const_val), .fork_mask(fork_mask)
  );

  always #5 clk = ~clk;

  task automatic check_w(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_p(string name, logic [NP-1:0] act, logic [NP-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NP-1:0] ready_of(int s1, int s2);
    logic [NP-1:0] r;
    bit h1, h2;
    for (int i = 0; i < NP; i++) begin
      h1 = (int'(sel_1) == i);
      h2 = !acc_mode && (int'(sel_2) == i);
      r[i] = (h1 || h2) && !(h1 && s1 == FD) && !(h2 && s2 == FD);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] alu(logic [2:0] o, logic [DW-1:0] a, logic [DW-1:0] b);
    int sh;
    sh = int'(b[SH-1:0]);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return a << sh;
      default: return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  // reference model temporaries
  logic [NP-1:0] mt_rdy, mt_dv, mt_acc_b;
  bit            mt_retire, mt_fire, mt_p1, mt_p2;
  logic [DW-1:0] mt_d1, mt_d2, mt_a, mt_b, mt_r;
  int            mt_s1, mt_s2, mt_n;

  // Reference model, one step per rising edge.
  always @(posedge clk) begin
    if (rst || clr) begin
      m_q1.delete(); m_q2.delete();
      m_tok = 1'b0; m_sent = '0; m_acc = const_val; m_cnt = 0; m_dout = '0;
    end else begin
      mt_rdy   = ready_of(m_q1.size(), m_q2.size());
      mt_dv    = m_tok ? (fork_mask & ~m_sent) : '0;
      mt_acc_b = mt_dv & dout_r;
      for (int i = 0; i < NP; i++) if (mt_acc_b[i]) got_mdl.push_back(m_dout);
      mt_retire = m_tok && (((m_sent | mt_acc_b) & fork_mask) == fork_mask);
      mt_fire   = (m_q1.size() > 0) && (acc_mode || m_q2.size() > 0) && (!m_tok || mt_retire);
      mt_s1 = int'(sel_1);
      mt_s2 = int'(sel_2);
      mt_p1 = 1'b0; mt_p2 = 1'b0; mt_d1 = '0; mt_d2 = '0;
      if (mt_s1 < NP) begin
        mt_p1 = din_v[mt_s1] && mt_rdy[mt_s1]; mt_d1 = din[mt_s1*DW +: DW];
      end else if (mt_s1 == NP) begin
        mt_p1 = (m_q1.size() < FD); mt_d1 = const_val;
      end
      if (!acc_mode && mt_s2 < NP) begin
        mt_p2 = din_v[mt_s2] && mt_rdy[mt_s2]; mt_d2 = din[mt_s2*DW +: DW];
      end else if (!acc_mode && mt_s2 == NP) begin
        mt_p2 = (m_q2.size() < FD); mt_d2 = const_val;
      end
      if (mt_fire) begin
        mt_a = m_q1.pop_front();
        mt_b = acc_mode ? m_acc : m_q2.pop_front();
        mt_r = alu(op, mt_a, mt_b);
        if (acc_mode) begin
          mt_n = m_cnt + 1;
          if (iterations != 0 && mt_n == int'(iterations)) begin
            m_acc = const_val; m_cnt = 0;
          end else begin
            m_acc = mt_r; m_cnt = mt_n % 65536;
          end
        end
      end
      if (mt_fire && fork_mask != 0) begin
        m_tok = 1'b1; m_dout = mt_r; m_sent = '0;
      end else if (mt_retire) begin
        m_tok = 1'b0; m_sent = '0;
      end else begin
        m_sent = m_sent | mt_acc_b;
      end
      if (mt_p1) m_q1.push_back(mt_d1);
      if (mt_p2) m_q2.push_back(mt_d2);
    end
  end

  // Per-cycle comparison against the model, and log of DUT deliveries.
  always @(negedge clk) begin
    if (chk_en) begin
      check_p("din_r", din_r, ready_of(m_q1.size(), m_q2.size()));
      check_p("dout_v", dout_v, m_tok ? (fork_mask & ~m_sent) : '0);
      if (m_tok && (fork_mask & ~m_sent) != 0) check_w("dout", dout, m_dout);
      for (int i = 0; i < NP; i++) begin
        if (dout_v[i] && dout_r[i]) begin
          got_dut.push_back(dout);
          dlv_dut[i]++;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_port(int p, logic [DW-1:0] v);
    din[p*DW +: DW] = v;
  endtask

  task automatic cfg(int s1, int s2, int o, bit am, int it, logic [DW-1:0] cv, logic [NP-1:0] mk);
    chk_en = 1'b0;
    din_v = '0;
    sel_1 = SW'(s1); sel_2 = SW'(s2); op = 3'(o); acc_mode = am;
    iterations = 16'(it); const_val = cv; fork_mask = mk;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    got_dut.delete(); got_mdl.delete();
    for (int i = 0; i < NP; i++) dlv_dut[i] = 0;
    chk_en = 1'b1;
  endtask

  // Compare both the DUT log and the model log against a literal sequence.
  task automatic check_seq(string name);
    check_w({name, "_n_dut"}, DW'(got_dut.size()), DW'(exp_q.size()));
    check_w({name, "_n_mdl"}, DW'(got_mdl.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_dut.size()) check_w({name, "_dut"}, got_dut[i], exp_q[i]);
      if (i < got_mdl.size()) check_w({name, "_mdl"}, got_mdl[i], exp_q[i]);
    end
  endtask

  initial begin
    alu_lit[0] = 32'hFFFFFFEF; alu_lit[1] = 32'hFFFFFFE9;
    alu_lit[2] = 32'hFFFFFFC4; alu_lit[3] = 32'h00000000;
    alu_lit[4] = 32'hFFFFFFEF; alu_lit[5] = 32'hFFFFFFEF;
    alu_lit[6] = 32'hFFFFFF60; alu_lit[7] = 32'hFFFFFFFD;

    rst = 1'b1; clr = 1'b0; din = '0; din_v = '0; dout_r = 4'b1111;
    sel_1 = 3'd0; sel_2 = 3'd1; op = 3'd0; acc_mode = 1'b0;
    iterations = 16'd0; const_val = 32'd0; fork_mask = 4'b0001;
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check_w("rst_dout", dout, 32'd0);
    check_p("rst_dout_v", dout_v, 4'b0000);
    check_p("rst_din_r", din_r, 4'b0011);

    // ADD of two ports: 5 + 7 -> 12, two cycles after the beat
    set_port(0, 32'd5); set_port(1, 32'd7); din_v = 4'b0011;
    tick();
    din_v = 4'b0000;
    tick();
    check_w("add_dout", dout, 32'd12);
    check_p("add_dout_v", dout_v, 4'b0001);
    tick(2);
    exp_q = '{32'd12};
    check_seq("add");

    // every ALU op with A = -20, B = 3
    for (int o = 0; o < 8; o++) begin
      cfg(0, 1, o, 1'b0, 0, 32'd0, 4'b0001);
      set_port(0, 32'hFFFFFFEC); set_port(1, 32'd3); din_v = 4'b0011;
      tick();
      din_v = 4'b0000;
      tick(3);
      exp_q = '{alu_lit[o]};
      check_seq("alu");
    end

    // constant operand and shift-left streaming at full rate
    cfg(0, NP, 6, 1'b0, 0, 32'd3, 4'b0001);
    for (int v = 1; v <= 3; v++) begin
      set_port(0, DW'(v)); din_v = 4'b0001;
      tick();
    end
    din_v = 4'b0000;
    tick(3);
    exp_q = '{32'd8, 32'd16, 32'd24};
    check_seq("shift");

    // accumulate with reload every 3 fires
    cfg(0, 1, 0, 1'b1, 3, 32'd0, 4'b0001);
    check_p("acc_din_r", din_r, 4'b0001);
    for (int v = 1; v <= 4; v++) begin
      set_port(0, DW'(v)); din_v = 4'b0001;
      tick();
    end
    din_v = 4'b0000;
    tick(3);
    exp_q = '{32'd1, 32'd3, 32'd6, 32'd4};
    check_seq("acc");

    // eager fork to ports 0 and 2, port 2 late
    cfg(0, NP, 0, 1'b0, 0, 32'd0, 4'b0101);
    dout_r = 4'b0001;
    set_port(0, 32'd9); din_v = 4'b0001;
    tick();
    din_v = 4'b0000;
    tick();
    check_p("fork_v0", dout_v, 4'b0101);
    tick();
    check_p("fork_v1", dout_v, 4'b0100);
    tick(2);
    check_p("fork_v3", dout_v, 4'b0100);
    dout_r = 4'b0101;
    tick();
    check_p("fork_done", dout_v, 4'b0000);
    tick(2);
    check_w("fork_p0_cnt", DW'(dlv_dut[0]), 32'd1);
    check_w("fork_p2_cnt", DW'(dlv_dut[2]), 32'd1);
    exp_q = '{32'd9, 32'd9};
    check_seq("fork");

    // backpressure: 4 beats offered, 3 accepted
    cfg(0, NP, 0, 1'b0, 0, 32'd0, 4'b0001);
    dout_r = 4'b0000;
    for (int v = 10; v <= 13; v++) begin
      set_port(0, DW'(v)); din_v = 4'b0001;
      tick();
    end
    din_v = 4'b0000;
    check_p("bp_din_r", din_r, 4'b0000);
    check_p("bp_dout_v", dout_v, 4'b0001);
    check_w("bp_dout", dout, 32'd10);
    dout_r = 4'b1111;
    tick(5);
    exp_q = '{32'd10, 32'd11, 32'd12};
    check_seq("bp");

    // clr with a partially delivered token and a queued operand
    cfg(0, 1, 0, 1'b1, 0, 32'd100, 4'b0011);
    dout_r = 4'b0001;
    set_port(0, 32'd1); din_v = 4'b0001;
    tick();
    set_port(0, 32'd2);
    tick();
    din_v = 4'b0000;
    tick();
    check_p("clr_pre", dout_v, 4'b0010);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_p("clr_dout_v", dout_v, 4'b0000);
    check_p("clr_din_r", din_r, 4'b0001);
    dout_r = 4'b0011;
    set_port(0, 32'd5); din_v = 4'b0001;
    tick();
    din_v = 4'b0000;
    tick(3);
    exp_q = '{32'd101, 32'd105, 32'd105};
    check_seq("clr");

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/processing_cell_fifo.md
# processing_cell_fifo

Parametrised next-generation CGRA processing cell. It selects two operands from `NUM_PORTS` neighbour inputs or a configured constant, and buffers each operand in a `FIFO_DEPTH`-entry FIFO. It computes an ALU result, optionally accumulated across a configured iteration count, and broadcasts the result to a masked set of neighbours through an eager fork. It sits in the CGRA grid in the same position as the current cell, driven by the same static per-cell configuration.

## Interface
- `DATA_WIDTH`, 32, datapath width.
- `NUM_PORTS`, 4, neighbour input/output ports (≥2).
- `FIFO_DEPTH`, 2, entries per operand FIFO (power of two, ≥2).
- `SEL_W`, `$clog2(NUM_PORTS+1)`, operand-select width (derived).

- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous flush, same effect as `rst`; `rst` has priority.
- `din`  in  `NUM_PORTS*DATA_WIDTH`  neighbour data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `din_v`  in  `NUM_PORTS`  per-port valid.
- `din_r`  out  `NUM_PORTS`  per-port ready.
- `dout`  out  `DATA_WIDTH`  result, shared by all destinations.
- `dout_v`  out  `NUM_PORTS`  per-destination valid.
- `dout_r`  in  `NUM_PORTS`  per-destination ready.
- `sel_1`, `sel_2`  in  `SEL_W`  operand source: values 0..NUM_PORTS-1 select a port, NUM_PORTS selects `const_val`, larger values select nothing (operand never valid).
- `op`  in  3  ALU operation.
- `acc_mode`  in  1  accumulate mode enable.
- `iterations`  in  16  accumulator reload period; 0 means never reload.
- `const_val`  in  `DATA_WIDTH`  constant operand and accumulator initial value.
- `fork_mask`  in  `NUM_PORTS`  destinations that must receive each result.

## Operation
- **Configuration:** config inputs are static while running. They are changed only under `rst`/`clr`, and are not reset.
- **Input routing:**
  - `din_r[i] = AND` over the operands whose `sel == i` of `~full` of that operand's FIFO.
  - A port selected by no operand has `din_r[i]=0`.
  - If both operands select the same port, a beat is pushed into both FIFOs at once.
- **FIFO push rules:**
  - A FIFO pushes on `src_v & ~full`.
  - A constant source is always valid.
  - `full` ignores a same-cycle pop, so there is no combinational ready path.
- **Fire condition:**
  - The cell fires when the required operands are non-empty and the output register is empty or retiring this cycle.
  - With `acc_mode=0`, both FIFOs are required.
  - With `acc_mode=1`, only FIFO1 is required; operand B is the accumulator and FIFO2 is neither read nor pushed (its `din_r` contribution is 0).
- **ALU**, results truncated to `DATA_WIDTH`:
  - 0 = A+B, 1 = A−B, 2 = A*B (low half), 3 = AND, 4 = OR, 5 = XOR.
  - 6 = A << B[$clog2(DATA_WIDTH)-1:0], 7 = A >>> B[same] (arithmetic).
  - In accumulate mode A = FIFO1 head and B = acc.
- **Accumulator:**
  - On each fire in accumulate mode, `acc <= result`, `cnt <= cnt+1`, and the result is emitted.
  - When `cnt+1 == iterations` (and `iterations != 0`), `acc <= const_val` and `cnt <= 0` instead.
  - Reset and `clr` load `acc = const_val`, `cnt = 0`.
- **Eager fork:**
  - The output register holds one token, plus per-destination `sent[NUM_PORTS]` flags.
  - `dout_v[i] = full & fork_mask[i] & ~sent[i]`; a destination's flag sets on `dout_v[i] & dout_r[i]`.
  - The token retires in the cycle where `(sent | (dout_v & dout_r)) ⊇ fork_mask`. All `sent` flags then clear.
  - Destinations accept independently, in any cycle order.
  - With `fork_mask=0`, results are computed and dropped: the register never fills and fires are unthrottled.

## Timing
- **Reset/clr values:** FIFOs empty, output register empty, `sent=0`, `dout_v=0`, `dout=0`, `acc=const_val`, `cnt=0`.
- `din_r` is valid in the cycle after reset deasserts.
- **Latency:** a beat accepted at edge N is at the FIFO head after N. It fires in cycle N+1, giving `dout_v` high after edge N+1 (2 cycles input-to-output).
- **Throughput:** 1 result per cycle when all masked destinations are ready every cycle.
- **Boundaries:**
  - A full FIFO drops `din_r` the cycle after the filling push, and raises it the cycle after a pop.
  - A simultaneous push and pop on a non-full FIFO keeps the occupancy constant.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **`rst`/`clr` mid-token:** the token is discarded, partially delivered destinations are not re-sent, and `dout_v` is 0 the next cycle.

## Test plan
- **ADD, both ports:** `sel_1=0`, `sel_2=1`, `op=0`, mask=0001; drive 5 and 7 together at cycle 0 -> `dout=12`, `dout_v=0001` at cycle 2.
- **Constant and shift:** `sel_2=NUM_PORTS`, `const_val=3`, `op=6`; stream 1,2,3 on port 0 -> outputs 8, 16, 24 at one per cycle.
- **Accumulate with reload:** `acc_mode=1`, `iterations=3`, `const_val=0`, `op=0`; inputs 1,2,3,4 -> outputs 1,3,6,4.
- **Eager fork:** mask=0101. `dout_r[0]=1` and `dout_r[2]=0` for 3 cycles, then `dout_r[2]=1` -> `dout_v[0]` drops after 1 cycle, the token retires when port 2 accepts, and port 0 never sees a duplicate.
- **Backpressure:** `FIFO_DEPTH=2`, `dout_r=0`; push 4 beats -> the output register holds 1 token, FIFOs hold 2, `din_r[0]=0` (3 beats accepted). Releasing `dout_r` delivers all 3 in order.
- **`clr` mid-operation:** assert `clr` with FIFOs half full and a token pending -> all `dout_v=0` and all selected `din_r=1` the next cycle; `acc=const_val`.
